// File: rtl/nor3_stim_monitor.sv
// Stimulus/monitor stage for a NOR3X0 cell: drives IN1..IN3 with a selectable pattern, checks QN
// one cycle later against ideal NOR, counts mismatches and QN toggles.
// Optional first-failure capture is built when NOR3_FAIL_LOG_EN is defined.
module nor3_stim_monitor #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             START,
  input  logic [1:0]       MODE,
  input  logic [CNT_W-1:0] NUM_VEC,
  output logic             IN1,
  output logic             IN2,
  output logic             IN3,
  input  logic             QN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] TOG_CNT,
  output logic [2:0]       FAIL_VEC,
  output logic [CNT_W-1:0] FAIL_IDX
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]       LfsrSeed = 3'b001;

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [2:0]       ctr_q, ctr_d;
  logic [2:0]       lfsr_q, lfsr_d;
  logic [2:0]       vec_q, vec_d;
  logic             exp_q, exp_d;
  logic             qn_prev_q, qn_prev_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] tog_q, tog_d;

  logic             mism;
  logic             start_ok;
  logic             last_vec;
  logic [2:0]       ctr_nxt;
  logic [2:0]       lfsr_nxt;

  // Vector for a given pattern position; ctr drives modes 0/1/3, the LFSR drives mode 2.
  function automatic logic [2:0] pat_vec(input logic [1:0] m, input logic [2:0] c,
                                         input logic [2:0] s);
    logic [2:0] v;
    v = 3'b000;
    unique case (m)
      2'd0: v = c;
      2'd1: v = c ^ (c >> 1);
      2'd2: v = s;
      2'd3: begin
        unique case (c)
          3'd1:    v = 3'b001;
          3'd3:    v = 3'b010;
          3'd5:    v = 3'b100;
          default: v = 3'b000;
        endcase
      end
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  // X/Z on QN must count as a mismatch, hence the case-inequality.
  assign mism     = (QN !== exp_q);
  assign start_ok = (state_q == StIdle) && START && (NUM_VEC != '0);
  assign last_vec = (idx_q == num_q - CntOne);
  assign ctr_nxt  = ((mode_q == 2'd3) && (ctr_q == 3'd5)) ? 3'd0 : ctr_q + 3'd1;
  assign lfsr_nxt = {lfsr_q[1:0], lfsr_q[2] ^ lfsr_q[1]};

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    num_d     = num_q;
    idx_d     = idx_q;
    ctr_d     = ctr_q;
    lfsr_d    = lfsr_q;
    vec_d     = vec_q;
    exp_d     = exp_q;
    qn_prev_d = qn_prev_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    tog_d     = tog_q;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          err_d = '0;
          tog_d = '0;
          if (NUM_VEC != '0) begin
            state_d = StRun;
            mode_d  = MODE;
            num_d   = NUM_VEC;
            idx_d   = '0;
            ctr_d   = 3'd0;
            lfsr_d  = LfsrSeed;
            vec_d   = pat_vec(MODE, 3'd0, LfsrSeed);
            exp_d   = ~|vec_d;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (mism && (err_q != '1)) begin
          err_d = err_q + CntOne;
        end
        // The first sample of a run has no predecessor to toggle from.
        if ((idx_q != '0) && (QN != qn_prev_q) && (tog_q != '1)) begin
          tog_d = tog_q + CntOne;
        end
        qn_prev_d = QN;
        if (last_vec) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          vec_d   = 3'b000;
        end else begin
          idx_d  = idx_q + CntOne;
          ctr_d  = ctr_nxt;
          lfsr_d = lfsr_nxt;
          vec_d  = pat_vec(mode_q, ctr_nxt, lfsr_nxt);
          exp_d  = ~|vec_d;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state_q   <= StIdle;
      mode_q    <= 2'd0;
      num_q     <= '0;
      idx_q     <= '0;
      ctr_q     <= 3'd0;
      lfsr_q    <= LfsrSeed;
      vec_q     <= 3'b000;
      exp_q     <= 1'b0;
      qn_prev_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= '0;
      tog_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      ctr_q     <= ctr_d;
      lfsr_q    <= lfsr_d;
      vec_q     <= vec_d;
      exp_q     <= exp_d;
      qn_prev_q <= qn_prev_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tog_q     <= tog_d;
    end
  end

  assign IN1     = vec_q[0];
  assign IN2     = vec_q[1];
  assign IN3     = vec_q[2];
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERR_CNT = err_q;
  assign TOG_CNT = tog_q;

`ifdef NOR3_FAIL_LOG_EN
  logic [2:0]       fail_vec_q, fail_vec_d;
  logic [CNT_W-1:0] fail_idx_q, fail_idx_d;

  always_comb begin
    fail_vec_d = fail_vec_q;
    fail_idx_d = fail_idx_q;
    if ((state_q == StIdle) && START) begin
      fail_vec_d = 3'b000;
      fail_idx_d = '0;
    end else if ((state_q == StRun) && mism && (err_q == '0)) begin
      // err_q is cleared at START, so zero here means this is the first mismatch.
      fail_vec_d = vec_q;
      fail_idx_d = idx_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      fail_vec_q <= 3'b000;
      fail_idx_q <= '0;
    end else begin
      fail_vec_q <= fail_vec_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  assign FAIL_VEC = fail_vec_q;
  assign FAIL_IDX = fail_idx_q;
`else
  assign FAIL_VEC = 3'b000;
  assign FAIL_IDX = '0;
`endif

  logic unused_start_ok;
  assign unused_start_ok = start_ok;

endmodule

// File: tb/tb_nor3_stim_monitor.sv
// Randomized self-checking bench for nor3_stim_monitor with an ideal/faulty NOR3 cell model.
// Honors NOR3_FAIL_LOG_EN the same way as the design.
module tb_nor3_stim_monitor;

  localparam int unsigned CntW = 16;

  logic            clk = 1'b0;
  logic            rstb;
  logic            start;
  logic [1:0]      mode;
  logic [CntW-1:0] num_vec;
  logic            in1, in2, in3;
  logic            qn;
  logic            busy, done;
  logic [CntW-1:0] err_cnt, tog_cnt, fail_idx;
  logic [2:0]      fail_vec;
  logic            flip;
  logic            stuck;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Cell model: ideal NOR3, optionally inverted per vector or stuck at 1.
  assign qn = stuck ? 1'b1 : (~(in1 | in2 | in3) ^ flip);

  nor3_stim_monitor #(.CNT_W(CntW)) dut (
    .CLK      (clk),
    .RSTB     (rstb),
    .START    (start),
    .MODE     (mode),
    .NUM_VEC  (num_vec),
    .IN1      (in1),
    .IN2      (in2),
    .IN3      (in3),
    .QN       (qn),
    .BUSY     (busy),
    .DONE     (done),
    .ERR_CNT  (err_cnt),
    .TOG_CNT  (tog_cnt),
    .FAIL_VEC (fail_vec),
    .FAIL_IDX (fail_idx)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pattern i of a run, straight from the sequence tables.
  function automatic logic [2:0] vec_at(input logic [1:0] m, input int i);
    int k;
    logic [2:0] v;
    v = 3'b000;
    case (m)
      2'd0: v = 3'(i % 8);
      2'd1: begin
        k = i % 8;
        v = 3'(k ^ (k / 2));
      end
      2'd2: begin
        case (i % 7)
          0: v = 3'b001;
          1: v = 3'b010;
          2: v = 3'b101;
          3: v = 3'b011;
          4: v = 3'b111;
          5: v = 3'b110;
          default: v = 3'b100;
        endcase
      end
      default: begin
        case (i % 6)
          1: v = 3'b001;
          3: v = 3'b010;
          5: v = 3'b100;
          default: v = 3'b000;
        endcase
      end
    endcase
    return v;
  endfunction

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_in"}, {29'd0, in3, in2, in1}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_err"}, {16'd0, err_cnt}, 32'd0);
    check_eq({tag, "_tog"}, {16'd0, tog_cnt}, 32'd0);
    check_eq({tag, "_fvec"}, {29'd0, fail_vec}, 32'd0);
    check_eq({tag, "_fidx"}, {16'd0, fail_idx}, 32'd0);
  endtask

  // One run: n vectors, flip_pct % chance of a wrong QN per vector, optional stuck-at-1,
  // optional START pulse (ignored) while vector glitch_at is driven.
  task automatic run_vec(input logic [1:0] m, input int n, input int flip_pct, input bit stk,
                         input int glitch_at);
    logic [2:0] v;
    bit         f, q, q_prev, ideal;
    int         errs, togs, first;
    logic [2:0] fvec;
    errs = 0; togs = 0; first = -1; fvec = 3'b000; q_prev = 1'b0;
    stuck = stk;
    flip  = 1'b0;
    @(negedge clk);
    start   = 1'b1;
    mode    = m;
    num_vec = CntW'(n);
    @(posedge clk); #1;
    start   = 1'b0;
    mode    = 2'($urandom);
    num_vec = CntW'($urandom);
    if (n == 0) begin
      check_eq("nv0_busy", {31'd0, busy}, 32'd0);
      check_eq("nv0_done", {31'd0, done}, 32'd1);
      check_eq("nv0_in", {29'd0, in3, in2, in1}, 32'd0);
      check_eq("nv0_err", {16'd0, err_cnt}, 32'd0);
      check_eq("nv0_tog", {16'd0, tog_cnt}, 32'd0);
      check_eq("nv0_fidx", {16'd0, fail_idx}, 32'd0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      v     = vec_at(m, i);
      ideal = (v == 3'b000);
      f     = ($urandom_range(99) < flip_pct);
      flip  = f;
      q     = stk ? 1'b1 : (ideal ^ f);
      if (q != ideal) begin
        errs++;
        if (first < 0) begin
          first = i;
          fvec  = v;
        end
      end
      if (i > 0 && q != q_prev) togs++;
      q_prev = q;
      check_eq("run_in", {29'd0, in3, in2, in1}, {29'd0, v});
      check_eq("run_busy", {31'd0, busy}, 32'd1);
      if (i == 0) check_eq("run_done_low", {31'd0, done}, 32'd0);
      start = (i == glitch_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
    flip  = 1'b0;
    stuck = 1'b0;
    check_eq("end_busy", {31'd0, busy}, 32'd0);
    check_eq("end_done", {31'd0, done}, 32'd1);
    check_eq("end_in", {29'd0, in3, in2, in1}, 32'd0);
    check_eq("end_err", {16'd0, err_cnt}, 32'(errs));
    check_eq("end_tog", {16'd0, tog_cnt}, 32'(togs));
`ifdef NOR3_FAIL_LOG_EN
    check_eq("end_fvec", {29'd0, fail_vec}, {29'd0, fvec});
    check_eq("end_fidx", {16'd0, fail_idx}, (first < 0) ? 32'd0 : 32'(first));
`else
    check_eq("end_fvec", {29'd0, fail_vec}, 32'd0);
    check_eq("end_fidx", {16'd0, fail_idx}, 32'd0);
`endif
    // Results must hold while idle.
    @(posedge clk); #1;
    check_eq("hold_err", {16'd0, err_cnt}, 32'(errs));
    check_eq("hold_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    rstb = 1'b0; start = 1'b0; mode = 2'd0; num_vec = '0; flip = 1'b0; stuck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("rst");
    rstb = 1'b1;
    @(posedge clk); #1;

    run_vec(2'd0, 0, 0, 1'b0, -1);
    run_vec(2'd0, 8, 0, 1'b0, -1);
    run_vec(2'd3, 6, 0, 1'b0, -1);
    run_vec(2'd2, 14, 0, 1'b0, -1);
    run_vec(2'd1, 8, 0, 1'b1, -1);
    run_vec(2'd0, 0, 0, 1'b0, -1);
    run_vec(2'd1, 12, 0, 1'b0, 4);
    run_vec(2'd2, 9, 40, 1'b0, 2);

    // Reset in the middle of a long run.
    @(negedge clk);
    start = 1'b1; mode = 2'd0; num_vec = CntW'(100);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check_eq("pre_rst_in", {29'd0, in3, in2, in1}, {29'd0, vec_at(2'd0, i)});
      @(posedge clk); #1;
    end
    rstb = 1'b0;
    @(posedge clk); #1;
    check_idle_zero("mid_rst");
    rstb = 1'b1;
    run_vec(2'd0, 100, 0, 1'b0, 50);

    for (int r = 0; r < 24; r++) begin
      run_vec(2'($urandom), int'($urandom_range(40)), (r % 3) * 25, 1'b0,
              int'($urandom_range(45)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nor3_stim_monitor.md
Name: nor3_stim_monitor

Overview:
Sequential stimulus/monitor stage for a NOR3X0 device-under-test instance in the power-test bench. It sits directly upstream and downstream of the cell: it drives the cell's IN1/IN2/IN3 with a selectable pattern and samples QN one cycle later. It checks QN against the ideal NOR, and counts mismatches and QN transitions for power/activity correlation.

Parameters:
CNT_W, 16, width of NUM_VEC, ERR_CNT, TOG_CNT and FAIL_IDX.

Ports:
CLK  input  1  rising-edge clock
RSTB  input  1  synchronous active-low reset
START  input  1  run request; sampled only in IDLE
MODE  input  2  pattern: 0 binary count, 1 Gray, 2 LFSR, 3 walking-one
NUM_VEC  input  CNT_W  vectors per run; sampled with START
IN1  output  1  stimulus bit 0 to DUT
IN2  output  1  stimulus bit 1 to DUT
IN3  output  1  stimulus bit 2 to DUT
QN  input  1  DUT output
BUSY  output  1  high while in RUN
DONE  output  1  high from run end until next accepted START or reset
ERR_CNT  output  CNT_W  QN mismatches in last run, saturating
TOG_CNT  output  CNT_W  QN transitions between consecutive samples, saturating
FAIL_VEC  output  3  {IN3,IN2,IN1} of first failing vector (optional feature)
FAIL_IDX  output  CNT_W  index of first failing vector (optional feature)

Behaviour:
- One clock. Reset is synchronous and active-low (RSTB sampled on CLK rising edge).
- Reset, including mid-run: state IDLE; IN1/IN2/IN3=0; BUSY=0; DONE=0; ERR_CNT=0; TOG_CNT=0; FAIL_VEC=0; FAIL_IDX=0. No partial results are retained.
- All outputs are registered. Vector V is packed as {IN3,IN2,IN1}.
- States: IDLE, RUN.
- IDLE + START=1 + NUM_VEC>0 on edge e0:
  - MODE and NUM_VEC latched; counters cleared; DONE=0; BUSY=1.
  - Vector 0 is driven from e0; state RUN.
- IDLE + START=1 + NUM_VEC=0: stay IDLE; DONE=1; counters cleared; IN stays 000.
- RUN: a new vector is driven at every edge e_i (i = 0..NUM_VEC-1). The expected value exp_i = ~(V_i[0]|V_i[1]|V_i[2]) is registered alongside it.
- Check latency 1: at edge e_{i+1}, QN is compared to exp_i. A mismatch increments ERR_CNT.
- Toggle: for i≥1, sampled QN_i != QN_{i-1} increments TOG_CNT. The first sample never counts, so TOG_CNT ≤ NUM_VEC-1.
- At edge e_N (N=NUM_VEC), the last sample is checked, then: state IDLE; BUSY=0; DONE=1; IN returns to 000. ERR_CNT and TOG_CNT are final at that same edge and hold until the next accepted START.
- START while BUSY is ignored. MODE/NUM_VEC changes during RUN are ignored.
- Counters saturate at all-ones and do not wrap.
- Patterns restart at each START and wrap within a run:
  - MODE 0: 000,001,…,111, then 000.
  - MODE 1: 000,001,011,010,110,111,101,100, repeat.
  - MODE 2: seed 001; next = {s[1:0], s[2]^s[1]}; sequence 001,010,101,011,111,110,100, repeat (period 7, never 000).
  - MODE 3: 000,001,000,010,000,100, repeat (period 6).
- X/Z on QN counts as a mismatch.

Optional Feature:
Macro NOR3_FAIL_LOG_EN.
- Defined: on the first mismatch of a run, FAIL_VEC captures V_i and FAIL_IDX captures i. Both hold until the next accepted START (which clears them to 0) or reset.
- Undefined: FAIL_VEC and FAIL_IDX are tied to 0. The ports remain present and no capture logic is built.

Test Plan:
- Ideal NOR3X0 DUT, MODE=0, NUM_VEC=8 -> BUSY for exactly 8 cycles; DONE=1; ERR_CNT=0; TOG_CNT=1 (QN 1,0,0,0,0,0,0,0).
- Ideal DUT, MODE=3, NUM_VEC=6 -> IN sequence 000,001,000,010,000,100; ERR_CNT=0; TOG_CNT=5.
- Ideal DUT, MODE=2, NUM_VEC=14 -> IN 001,010,101,011,111,110,100, repeated twice; ERR_CNT=0; TOG_CNT=0.
- QN stuck at 1, MODE=1, NUM_VEC=8 -> ERR_CNT=7; TOG_CNT=0. With NOR3_FAIL_LOG_EN: FAIL_VEC=001, FAIL_IDX=1.
- Run MODE=0, NUM_VEC=100; drop RSTB for 1 cycle at vector 20 -> all outputs 0 next edge. A new START is then accepted; the run completes with ERR_CNT=0.
- START with NUM_VEC=0 -> BUSY never set; DONE=1 next edge; counts 0. START pulsed mid-run -> ignored; run length unchanged.
